// File: rtl/pll_phase_ctrl.sv
// Sequencer for PLL dynamic phase shifting: sel/dir setup, step strobes, settle gaps, final load pulse.
// Optional per-output signed step accumulator, enabled by defining PLL_PHASE_CTRL_ACCUM_EN.
module pll_phase_ctrl #(
    parameter int PULSE_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int LOCK_FILTER   = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pll_locked,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_sel,
    input  logic        req_dir,
    input  logic [7:0]  req_steps,
    output logic [1:0]  phasesel,
    output logic        phasedir,
    output logic        phasestep,
    output logic        phaseloadreg,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        lock_ok,
    output logic [31:0] phase_acc
);

    localparam int MAX_CYC = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam int FW      = $clog2(LOCK_FILTER + 1);

    localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [FW-1:0] FILT_LAST   = FW'(LOCK_FILTER - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, STROBE, SETTLE, LOAD, FINISH
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    rem_q, rem_d;
    logic [1:0]    sel_q, sel_d;
    logic          dir_q, dir_d;
    logic          err_q, err_d;

    logic          sync1_q, sync2_q;
    logic [FW-1:0] filt_q, filt_d;
    logic          lock_ok_q, lock_ok_d;

    // Lock qualifier: count consecutive synchronized-high clocks, drop on the first low one.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        filt_d    = '0;
        lock_ok_d = 1'b0;
        if (sync2_q) begin
            filt_d    = (filt_q == FILT_LAST) ? filt_q : filt_q + 1'b1;
            lock_ok_d = (filt_q == FILT_LAST);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            filt_q    <= '0;
            lock_ok_q <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            sel_q     <= '0;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so sync1 -> sync2 really forms two flop stages.
            sync1_q   <= pll_locked;
            sync2_q   <= sync1_q;
            filt_q    <= filt_d;
            lock_ok_q <= lock_ok_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            sel_q     <= sel_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        err_d   = err_q;

        // Losing lock mid-sequence abandons the remaining steps but still reports completion.
        if (state_q != IDLE && !lock_ok_q) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = (state_q == FINISH) ? IDLE : FINISH;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid && lock_ok_q) begin
                        sel_d   = req_sel;
                        dir_d   = req_dir;
                        rem_d   = req_steps;
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = (req_steps == 8'd0) ? FINISH : SETUP;
                    end
                end
                SETUP: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == PULSE_LAST) begin
                        cnt_d   = '0;
                        state_d = STROBE;
                    end
                end
                STROBE: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == PULSE_LAST) begin
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end
                end
                SETTLE: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        rem_d   = rem_q - 8'd1;
                        state_d = (rem_q == 8'd1) ? LOAD : STROBE;
                    end
                end
                LOAD: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == PULSE_LAST) begin
                        cnt_d   = '0;
                        state_d = FINISH;
                    end
                end
                FINISH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Strobes are gated by lock_ok so a lock loss releases them one clock before the FSM aborts.
    always_comb begin
        req_ready    = (state_q == IDLE) && lock_ok_q;
        busy         = (state_q != IDLE);
        done         = (state_q == FINISH);
        phasestep    = !((state_q == STROBE) && lock_ok_q);
        phaseloadreg = !((state_q == LOAD) && lock_ok_q);
    end

    assign phasesel = sel_q;
    assign phasedir = dir_q;
    assign err      = err_q;
    assign lock_ok  = lock_ok_q;

`ifdef PLL_PHASE_CTRL_ACCUM_EN
    logic [7:0] acc_q [4];
    logic       step_done;

    // A strobe counts only when it runs its full width with lock still held.
    assign step_done = (state_q == STROBE) && (cnt_q == PULSE_LAST) && lock_ok_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: this small array must come up at zero, so it is reset like ordinary flops.
            for (int i = 0; i < 4; i++) acc_q[i] <= '0;
        end else if (step_done) begin
            acc_q[sel_q] <= acc_q[sel_q] + (dir_q ? 8'h01 : 8'hFF);
        end
    end

    assign phase_acc = {acc_q[3], acc_q[2], acc_q[1], acc_q[0]};
`else
    assign phase_acc = '0;
`endif

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Self-checking bench for pll_phase_ctrl: expected waveforms are built from the step/settle/load
// timeline and the accumulator from net step arithmetic.
module tb_pll_phase_ctrl;

    localparam int PULSE  = 4;
    localparam int SETTLE = 16;
    localparam int LOCKF  = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        pll_locked;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_sel;
    logic        req_dir;
    logic [7:0]  req_steps;
    logic [1:0]  phasesel;
    logic        phasedir;
    logic        phasestep;
    logic        phaseloadreg;
    logic        busy;
    logic        done;
    logic        err;
    logic        lock_ok;
    logic [31:0] phase_acc;

    int checks = 0;
    int errors = 0;
    logic [7:0] acc_m [4];

    pll_phase_ctrl #(
        .PULSE_CYCLES (PULSE),
        .SETTLE_CYCLES(SETTLE),
        .LOCK_FILTER  (LOCKF)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_sel     (req_sel),
        .req_dir     (req_dir),
        .req_steps   (req_steps),
        .phasesel    (phasesel),
        .phasedir    (phasedir),
        .phasestep   (phasestep),
        .phaseloadreg(phaseloadreg),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .lock_ok     (lock_ok),
        .phase_acc   (phase_acc)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] exp_acc();
`ifdef PLL_PHASE_CTRL_ACCUM_EN
        return {acc_m[3], acc_m[2], acc_m[1], acc_m[0]};
`else
        return 32'h0;
`endif
    endfunction

    task automatic scramble();
        req_valid = 1'b0;
        req_sel   = 2'($urandom_range(0, 3));
        req_dir   = 1'($urandom_range(0, 1));
        req_steps = 8'($urandom_range(0, 255));
    endtask

    task automatic accept(input logic [1:0] sel, input logic dir, input logic [7:0] steps,
                          output bit ok);
        ok = 1'b0;
        @(negedge clock);
        req_sel = sel; req_dir = dir; req_steps = steps; req_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (req_ready === 1'b1) begin
                @(posedge clock);
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) req_valid = 1'b0;
    endtask

    task automatic wait_lock(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (lock_ok === 1'b1) begin got = 1'b1; break; end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s: lock_ok never rose within 40 clocks", tag);
        end
    endtask

    // One request: expected per-cycle {phasestep, phaseloadreg, done} from the timeline rules.
    task automatic run_request(input logic [1:0] sel, input logic dir, input int steps,
                               input string tag);
        logic [2:0] exp_q[$];
        logic [2:0] obs_q[$];
        bit ok, side_bad, done_seen;
        int bad_idx;
        if (steps == 0) exp_q.push_back(3'b111);
        else begin
            repeat (PULSE) exp_q.push_back(3'b110);
            for (int s = 0; s < steps; s++) begin
                repeat (PULSE)  exp_q.push_back(3'b010);
                repeat (SETTLE) exp_q.push_back(3'b110);
            end
            repeat (PULSE) exp_q.push_back(3'b100);
            exp_q.push_back(3'b111);
        end
        accept(sel, dir, 8'(steps), ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s accept: req_ready stayed low, required high", tag);
            return;
        end
        acc_m[sel] = acc_m[sel] + 8'(dir ? steps : -steps);
        side_bad = 1'b0; done_seen = 1'b0;
        for (int k = 0; k < exp_q.size() + 8 && !done_seen; k++) begin
            #1;
            obs_q.push_back({phasestep, phaseloadreg, done});
            if (busy !== 1'b1 || phasesel !== sel || phasedir !== dir) side_bad = 1'b1;
            done_seen = (done === 1'b1);
            @(negedge clock);
            scramble();
            @(posedge clock);
        end
        bad_idx = -1;
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
            if (obs_q[k] !== exp_q[k] && bad_idx < 0) bad_idx = k;
        checks++;
        if (bad_idx >= 0 || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s waveform: %0d cycles got, %0d required, first bad cycle %0d got %b req %b",
                     tag, obs_q.size(), exp_q.size(), bad_idx,
                     (bad_idx >= 0) ? obs_q[bad_idx] : 3'b000, (bad_idx >= 0) ? exp_q[bad_idx] : 3'b000);
        end
        checks++;
        if (side_bad) begin
            errors++;
            $display("FAIL %s busy/sel/dir: not held at busy=1 sel=%0d dir=%0d during sequence", tag, sel, dir);
        end
        #1;
        checks++;
        if ({busy, done, err, phasesel, phasedir} !== {3'b000, sel, dir}) begin
            errors++;
            $display("FAIL %s idle: busy/done/err/sel/dir got %b required %b", tag,
                     {busy, done, err, phasesel, phasedir}, {3'b000, sel, dir});
        end
        checks++;
        if (phase_acc !== exp_acc()) begin
            errors++;
            $display("FAIL %s phase_acc: got %h required %h", tag, phase_acc, exp_acc());
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({phasestep, phaseloadreg, phasesel, phasedir, busy, done, err, lock_ok, req_ready}
                !== 10'b11_00_0_00000) begin
            errors++;
            $display("FAIL reset outputs: got %b required %b",
                     {phasestep, phaseloadreg, phasesel, phasedir, busy, done, err, lock_ok, req_ready},
                     10'b11_00_0_00000);
        end
        checks++;
        if (phase_acc !== 32'h0) begin
            errors++;
            $display("FAIL reset phase_acc: got %h required 0", phase_acc);
        end
    endtask

    task automatic test_lock();
        int n = 0;
        @(negedge clock);
        reset_n = 1'b1;
        pll_locked = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            if (lock_ok === 1'b1) begin n = i; break; end
        end
        checks++;
        if (n != 2 + LOCKF) begin
            errors++;
            $display("FAIL lock_latency: lock_ok rose after %0d clocks, required %0d", n, 2 + LOCKF);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL lock_ready: req_ready got %b required 1", req_ready);
        end
    endtask

    task automatic test_directed();
        run_request(2'd3, 1'b1, 3, "three_steps");
        run_request(2'd2, 1'b0, 0, "zero_steps");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            run_request(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 4)), $sformatf("random%0d", i));
    endtask

    task automatic test_no_accept();
        bit bad = 1'b0;
        @(negedge clock);
        pll_locked = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        req_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock); #1;
            if (busy !== 1'b0 || req_ready !== 1'b0 || lock_ok !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL unlocked_no_accept: busy/req_ready/lock_ok went high, required all 0");
        end
        @(negedge clock);
        req_valid = 1'b0;
        pll_locked = 1'b1;
        wait_lock("relock_after_unlocked");
    endtask

    task automatic test_abort();
        bit ok, got, load_seen, done_got, hold_bad;
        int falls, n;
        logic prev;
        falls = 0; prev = 1'b1; n = 0; got = 1'b0; load_seen = 1'b0; done_got = 1'b0; hold_bad = 1'b0;
        accept(2'd1, 1'b0, 8'd5, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort accept: req_ready stayed low, required high");
            return;
        end
        for (int k = 0; k < 200; k++) begin
            #1;
            if (phasestep === 1'b0 && prev === 1'b1) falls++;
            prev = phasestep;
            if (falls == 2) break;
            @(negedge clock);
            req_valid = 1'b0;
            @(posedge clock);
        end
        checks++;
        if (falls != 2) begin
            errors++;
            $display("FAIL abort second_strobe: saw %0d strobes, required 2", falls);
            return;
        end
        pll_locked = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clock); #1;
            if (phaseloadreg === 1'b0) load_seen = 1'b1;
            if (phasestep === 1'b1) begin n = i; got = 1'b1; break; end
        end
        checks++;
        if (!got || n > 3) begin
            errors++;
            $display("FAIL abort strobe_end: phasestep high after %0d clocks, required at most 3", n);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (phaseloadreg === 1'b0) load_seen = 1'b1;
            if (done === 1'b1) begin done_got = 1'b1; break; end
        end
        checks++;
        if (!done_got || err !== 1'b1) begin
            errors++;
            $display("FAIL abort done_err: done seen %b err %b, required 1 1", done_got, err);
        end
        checks++;
        if (load_seen) begin
            errors++;
            $display("FAIL abort load: phaseloadreg went low, required none");
        end
        acc_m[1] = acc_m[1] - 8'd1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (req_ready !== 1'b0 || busy !== 1'b0) hold_bad = 1'b1;
        end
        checks++;
        if (hold_bad) begin
            errors++;
            $display("FAIL abort ready_low: req_ready/busy high while unlocked, required 0");
        end
        checks++;
        if (phase_acc !== exp_acc()) begin
            errors++;
            $display("FAIL abort phase_acc: got %h required %h", phase_acc, exp_acc());
        end
        pll_locked = 1'b1;
        wait_lock("relock_after_abort");
        checks++;
        if (req_ready !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL abort sticky: req_ready %b err %b, required 1 1", req_ready, err);
        end
        run_request(2'd2, 1'b1, 0, "err_clear");
    endtask

    task automatic test_wrap();
        run_request(2'd0, 1'b1, 128, "wrap_up");
        checks++;
`ifdef PLL_PHASE_CTRL_ACCUM_EN
        if (phase_acc[7:0] !== 8'h80) begin
            errors++;
            $display("FAIL wrap_0x80: got %h required 80", phase_acc[7:0]);
        end
`else
        if (phase_acc !== 32'h0) begin
            errors++;
            $display("FAIL acc_disabled: got %h required 0", phase_acc);
        end
`endif
        run_request(2'd0, 1'b0, 1, "wrap_down");
    endtask

    task automatic test_reset_mid();
        bit ok, bad;
        bad = 1'b0;
        accept(2'd3, 1'b1, 8'd2, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_mid accept: req_ready stayed low, required high");
            return;
        end
        @(negedge clock);
        req_valid = 1'b0;
        repeat (2 * PULSE + 4) @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b1 || phasestep !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid settle: busy %b phasestep %b, required 1 1", busy, phasestep);
        end
        #1;
        reset_n = 1'b0;
        acc_m = '{default: 8'h00};
        #1;
        test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            if (phasestep !== 1'b1 || phaseloadreg !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_mid hold: strobe or busy seen during reset");
        end
        @(negedge clock);
        reset_n = 1'b1;
        wait_lock("relock_after_reset");
        run_request(2'd2, 1'b0, 1, "after_reset");
    endtask

    initial begin
        acc_m = '{default: 8'h00};
        reset_n = 1'b1; pll_locked = 1'b0;
        req_valid = 1'b0; req_sel = '0; req_dir = 1'b0; req_steps = '0;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        test_reset();
        test_lock();
        test_directed();
        test_random();
        test_no_accept();
        test_abort();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
